my_keypad_scan: RTL and testbench
=================================

// Module: my_keypad_scan
// PURPOSE
//   Scanned 4x4 hex keypad reader; input-side counterpart of the multiplexed
//   7-segment display driver. Drives one row low at a time and samples four
//   pulled-up column inputs. Debounces over whole scan frames, then reports the
//   pressed key as a 4-bit hex code (0..F) that can feed the 7-segment digit
//   driver directly.
// PARAMETERS
//   SCAN_DIV  50000  clk cycles per row slot (>= 4); frame = 4*SCAN_DIV cycles
//   DEBOUNCE  3      consecutive agreeing frames to accept a press or release (>= 1)
// PORTS
//   clk        in   1  single system clock
//   rst        in   1  asynchronous, active-high reset
//   en         in   1  scan enable; 0 = idle, rows released
//   col        in   4  column sense, active-low (external pull-ups), asynchronous
//   row        out  4  row drive, active-low one-hot; 4'b1111 when idle
//   key        out  4  hex code of last accepted key = {row_idx[1:0], col_idx[1:0]}
//   key_valid  out  1  one-cycle pulse when a new key is accepted
//   key_down   out  1  level: accepted key currently held
// BEHAVIOUR
//   Reset (async, rst=1): row=4'b1111, key=0, key_valid=0, key_down=0, FSM=IDLE,
//     slot counter=0, row index=0, debounce counters=0, frame accumulator cleared.
//   Column sync: col passes through a 2-flop synchronizer before any use.
//   Scan: slot counter runs 0..SCAN_DIV-1 and then wraps. row = ~(4'b0001 << ridx).
//     Synced col is sampled at count SCAN_DIV-1. ridx advances 0->1->2->3->0 at the wrap.
//     Slot length >= 4 covers settle time plus synchronizer delay.
//   Frame result (evaluated at the row-3 sample):
//     NONE    = no low column bit in the frame
//     SINGLE(c) = exactly one low bit; c = 4*ridx + col_idx
//     MULTI   = two or more low bits
//   FSM, updated on the frame-end cycle. Outputs are registered and visible the next cycle.
//     IDLE: SINGLE(c): if c==cand then pcnt++ else {cand<=c, pcnt<=1}.
//           NONE/MULTI: pcnt<=0.
//           When pcnt reaches DEBOUNCE: go to HELD, key<=cand, key_down<=1,
//           key_valid=1 for exactly one cycle.
//     HELD: SINGLE(key) or MULTI: rcnt<=0 (rollover keys are ignored).
//           NONE or SINGLE(other): rcnt++.
//           When rcnt reaches DEBOUNCE: go to IDLE, key_down<=0, pcnt<=0.
//           key holds its value.
//     A new key is reported only after a debounced release (no n-key rollover).
//   Latency: a press that is stable from frame start gives key_valid one cycle after the
//     row-3 sample of the DEBOUNCE-th frame.
//   en=0 (takes effect next edge): row=4'b1111; slot counter, ridx, pcnt and rcnt cleared;
//     FSM=IDLE; key_down=0; key_valid=0; key retained.
//     On en=1, scan restarts at row 0, count 0, and a fresh frame begins.
//   rst mid-scan: the partial frame is discarded and no pulse is emitted.
//   Counter widths: slot $clog2(SCAN_DIV); pcnt/rcnt $clog2(DEBOUNCE+1). No overflow:
//     both saturate at DEBOUNCE.
// TESTING (SCAN_DIV=4, DEBOUNCE=3, frame=16 cycles)
//   1. Reset, then en=1, col=4'hF -> row cycles 1110,1101,1011,0111, 4 cycles each;
//      key=0, key_down=0, no key_valid pulse.
//   2. Hold key row2/col1 (col=4'b1101 while row=1011) -> exactly one key_valid after
//      frame 3 with key=4'h9 and key_down=1; 10 further held frames give no extra pulse.
//   3. Bounce code 9 on and off on alternate frames for 4 frames, then hold -> single
//      pulse only after 3 stable frames.
//   4. From IDLE, press codes 1 and 6 together for 5 frames -> no pulse, key_down=0,
//      key unchanged.
//   5. Held 9, released 2 frames, re-pressed -> key_down stays 1, no pulse.
//      Then released 3 frames -> key_down=0, key still 9.
//   6. en=0 (or rst pulse) mid-frame during a held key -> row=4'b1111 and key_down=0 next
//      cycle. On re-enable the scan starts at row=1110, and a re-press needs 3 full frames.

Source files
------------

// File: rtl/my_keypad_scan.sv
// 4x4 hex keypad scanner: one active-low row per slot, synchronized column sense,
// frame-level debounce of press and release, registered hex key code outputs.
module my_keypad_scan #(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_down
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HELD = 1'b1
  } state_t;

  // Number of low (pressed) columns, saturated at 2 since only 0/1/many matters.
  function automatic logic [1:0] f_low_count(input logic [3:0] lows);
    logic [2:0] sum;
    sum = {2'b00, lows[0]} + {2'b00, lows[1]} + {2'b00, lows[2]} + {2'b00, lows[3]};
    if (sum > 3'd1) begin
      f_low_count = 2'd2;
    end else begin
      f_low_count = sum[1:0];
    end
  endfunction

  function automatic logic [1:0] f_low_index(input logic [3:0] lows);
    casez (lows)
      4'b???1: f_low_index = 2'd0;
      4'b??10: f_low_index = 2'd1;
      4'b?100: f_low_index = 2'd2;
      4'b1000: f_low_index = 2'd3;
      default: f_low_index = 2'd0;
    endcase
  endfunction

  logic [3:0]    r_col_s1, r_col_s2;
  logic          r_active;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_ridx;
  logic [3:0]    r_row;
  logic [1:0]    r_nlow;
  logic [3:0]    r_acode;
  state_t        r_state;
  logic [3:0]    r_cand;
  logic [DW-1:0] r_pcnt, r_rcnt;
  logic [3:0]    r_key;
  logic          r_key_down, r_key_valid;

  logic          w_active_n;
  logic [CW-1:0] w_cnt_n;
  logic [1:0]    w_ridx_n;
  logic [3:0]    w_row_n;
  logic          w_sample, w_frame_end;
  logic [3:0]    w_lows;
  logic [2:0]    w_sum;
  logic [1:0]    w_tot;
  logic [3:0]    w_code;
  logic [1:0]    w_nlow_n;
  logic [3:0]    w_acode_n;
  state_t        w_state_n;
  logic [3:0]    w_cand_n;
  logic [DW-1:0] w_pcnt_n, w_rcnt_n, w_pcnt_inc, w_rcnt_inc;
  logic [3:0]    w_key_n;
  logic          w_key_down_n, w_key_valid_n;

  assign row       = r_row;
  assign key       = r_key;
  assign key_valid = r_key_valid;
  assign key_down  = r_key_down;

  assign w_sample    = en && r_active && (r_cnt == LAST);
  assign w_frame_end = w_sample && (r_ridx == 2'd3);
  assign w_lows      = ~r_col_s2;
  assign w_sum       = {1'b0, r_nlow} + {1'b0, f_low_count(w_lows)};
  assign w_tot       = (w_sum > 3'd1) ? 2'd2 : w_sum[1:0];
  assign w_code      = (r_nlow == 2'd0) ? {r_ridx, f_low_index(w_lows)} : r_acode;
  assign w_pcnt_inc  = (r_pcnt == DMAX) ? DMAX : r_pcnt + DW'(1);
  assign w_rcnt_inc  = (r_rcnt == DMAX) ? DMAX : r_rcnt + DW'(1);

  // Scan sequencing: the first enabled cycle only arms the scan so row 0 gets a full slot.
  always_comb begin
    w_active_n = 1'b1;
    w_cnt_n    = r_cnt;
    w_ridx_n   = r_ridx;
    if (!en) begin
      w_active_n = 1'b0;
      w_cnt_n    = {CW{1'b0}};
      w_ridx_n   = 2'd0;
    end else if (!r_active) begin
      w_cnt_n    = {CW{1'b0}};
      w_ridx_n   = 2'd0;
    end else if (r_cnt == LAST) begin
      w_cnt_n    = {CW{1'b0}};
      w_ridx_n   = r_ridx + 2'd1;
    end else begin
      w_cnt_n    = r_cnt + CW'(1);
    end
    w_row_n = w_active_n ? ~(4'b0001 << w_ridx_n) : 4'b1111;
  end

  // Frame accumulator: saturated low-bit count plus the code of the first low bit seen.
  always_comb begin
    w_nlow_n  = r_nlow;
    w_acode_n = r_acode;
    if (!en || !r_active || w_frame_end) begin
      w_nlow_n  = 2'd0;
      w_acode_n = 4'd0;
    end else if (w_sample) begin
      w_nlow_n  = w_tot;
      w_acode_n = w_code;
    end else begin
      w_nlow_n  = r_nlow;
      w_acode_n = r_acode;
    end
  end

  // Debounce FSM next state; w_tot 1 = single key w_code, 2 = multiple keys.
  always_comb begin
    w_state_n     = r_state;
    w_cand_n      = r_cand;
    w_pcnt_n      = r_pcnt;
    w_rcnt_n      = r_rcnt;
    w_key_n       = r_key;
    w_key_down_n  = r_key_down;
    w_key_valid_n = 1'b0;
    if (!en) begin
      w_state_n    = S_IDLE;
      w_pcnt_n     = {DW{1'b0}};
      w_rcnt_n     = {DW{1'b0}};
      w_key_down_n = 1'b0;
    end else if (w_frame_end) begin
      case (r_state)
        S_IDLE: begin
          if (w_tot == 2'd1) begin
            if (w_code == r_cand) begin
              w_pcnt_n = w_pcnt_inc;
            end else begin
              w_cand_n = w_code;
              w_pcnt_n = DW'(1);
            end
          end else begin
            w_pcnt_n = {DW{1'b0}};
          end
          if (w_pcnt_n == DMAX) begin
            w_state_n     = S_HELD;
            w_key_n       = w_cand_n;
            w_key_down_n  = 1'b1;
            w_key_valid_n = 1'b1;
            w_rcnt_n      = {DW{1'b0}};
          end else begin
            w_state_n     = S_IDLE;
          end
        end
        S_HELD: begin
          if ((w_tot == 2'd1 && w_code == r_key) || w_tot == 2'd2) begin
            w_rcnt_n = {DW{1'b0}};
          end else begin
            w_rcnt_n = w_rcnt_inc;
          end
          if (w_rcnt_n == DMAX) begin
            w_state_n    = S_IDLE;
            w_key_down_n = 1'b0;
            w_pcnt_n     = {DW{1'b0}};
            w_rcnt_n     = {DW{1'b0}};
          end else begin
            w_state_n    = S_HELD;
          end
        end
        default: begin
          w_state_n    = S_IDLE;
          w_key_down_n = 1'b0;
          w_pcnt_n     = {DW{1'b0}};
          w_rcnt_n     = {DW{1'b0}};
        end
      endcase
    end else begin
      w_state_n = r_state;
    end
  end

  // Column synchronizer, released (all-high) after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col_s1 <= 4'hF;
      r_col_s2 <= 4'hF;
    end else begin
      r_col_s1 <= col;
      r_col_s2 <= r_col_s1;
    end
  end

  // Scan counters, row drive and frame accumulator registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active <= 1'b0;
      r_cnt    <= {CW{1'b0}};
      r_ridx   <= 2'd0;
      r_row    <= 4'b1111;
      r_nlow   <= 2'd0;
      r_acode  <= 4'd0;
    end else begin
      r_active <= w_active_n;
      r_cnt    <= w_cnt_n;
      r_ridx   <= w_ridx_n;
      r_row    <= w_row_n;
      r_nlow   <= w_nlow_n;
      r_acode  <= w_acode_n;
    end
  end

  // Debounce FSM state and registered key outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cand      <= 4'd0;
      r_pcnt      <= {DW{1'b0}};
      r_rcnt      <= {DW{1'b0}};
      r_key       <= 4'd0;
      r_key_down  <= 1'b0;
      r_key_valid <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_cand      <= w_cand_n;
      r_pcnt      <= w_pcnt_n;
      r_rcnt      <= w_rcnt_n;
      r_key       <= w_key_n;
      r_key_down  <= w_key_down_n;
      r_key_valid <= w_key_valid_n;
    end
  end

endmodule

// File: tb/tb_my_keypad_scan.sv
// Bench for my_keypad_scan: a keypad matrix model drives col from row, and a
// frame-level debounce model plus stimulus tables supply expected outputs.
module tb_my_keypad_scan;
  localparam int SD  = 4;
  localparam int DB  = 3;
  localparam int FRM = 4 * SD;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [3:0] col, row, key;
  logic       key_valid, key_down;
  logic [15:0] pressed = 16'h0000;

  int errors = 0;
  int checks = 0;

  my_keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk(clk), .rst(rst), .en(en), .col(col),
    .row(row), .key(key), .key_valid(key_valid), .key_down(key_down)
  );

  always #5 clk = ~clk;

  // Switch matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row[r] && pressed[4*r+c]) col[c] = 1'b0;
  end

  typedef struct {
    logic [15:0] mask;
    int          reps;
    logic        pulse;
    logic [3:0]  key;
    logic        down;
  } vec_t;
  vec_t vecs[$];

  // Frame-level reference: keys seen per frame, counted against DEBOUNCE.
  logic m_held;
  int   m_key, m_cand, m_pcnt, m_rcnt, m_pulse;

  task automatic model_reset();
    m_held = 1'b0; m_key = 0; m_cand = 0; m_pcnt = 0; m_rcnt = 0; m_pulse = 0;
  endtask

  task automatic model_disable();
    m_held = 1'b0; m_pcnt = 0; m_rcnt = 0; m_pulse = 0;
  endtask

  task automatic model_step(input logic [15:0] mask);
    int n, idx;
    n = $countones(mask);
    idx = 0;
    for (int i = 15; i >= 0; i--) if (mask[i]) idx = i;
    m_pulse = 0;
    if (!m_held) begin
      if (n == 1) begin
        if (idx == m_cand) m_pcnt = (m_pcnt < DB) ? m_pcnt + 1 : DB;
        else begin m_cand = idx; m_pcnt = 1; end
      end else m_pcnt = 0;
      if (m_pcnt == DB) begin
        m_held = 1'b1; m_key = m_cand; m_pulse = 1; m_rcnt = 0;
      end
    end else begin
      if ((n == 1 && idx == m_key) || n >= 2) m_rcnt = 0;
      else m_rcnt = (m_rcnt < DB) ? m_rcnt + 1 : DB;
      if (m_rcnt == DB) begin
        m_held = 1'b0; m_pcnt = 0; m_rcnt = 0;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [15:0] m, input int n, input logic p, input logic [3:0] k,
                     input logic d);
    vec_t v;
    v.mask = m; v.reps = n; v.pulse = p; v.key = k; v.down = d;
    vecs.push_back(v);
  endtask

  // Entered at the first cycle of a frame; leaves at the first cycle of the next,
  // where the decision taken at the end of this frame is visible.
  task automatic run_frame(input logic [15:0] mask, input int exp_pulse, input int exp_key,
                           input int exp_down, input string tag);
    int rowerr, spurious;
    logic [3:0] exp_row;
    rowerr = 0; spurious = 0;
    pressed = mask;
    for (int i = 0; i < FRM; i++) begin
      exp_row = ~(4'b0001 << (i / SD));
      if (row !== exp_row) rowerr++;
      if (i > 0 && key_valid !== 1'b0) spurious++;
      @(negedge clk);
    end
    chk({tag, "_row_seq"}, rowerr, 0);
    chk({tag, "_extra_pulse"}, spurious, 0);
    chk({tag, "_key_valid"}, int'(key_valid), exp_pulse);
    chk({tag, "_key"}, int'(key), exp_key);
    chk({tag, "_key_down"}, int'(key_down), exp_down);
  endtask

  task automatic model_frame(input logic [15:0] mask, input string tag);
    model_step(mask);
    run_frame(mask, m_pulse, m_key, int'(m_held), tag);
  endtask

  logic [15:0] rmask;

  initial begin
    rst = 1'b1; en = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_row", int'(row), 4'hF);
    chk("rst_key", int'(key), 0);
    chk("rst_key_valid", int'(key_valid), 0);
    chk("rst_key_down", int'(key_down), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_row", int'(row), 4'hF);
    en = 1'b1;
    @(negedge clk);
    chk("start_row", int'(row), 4'b1110);

    // Quiet, clean press of 9, rollover-free hold, re-press, bounce, multi, release rules.
    add(16'h0000, 2, 1'b0, 4'h0, 1'b0);
    add(16'h0200, 2, 1'b0, 4'h0, 1'b0);
    add(16'h0200, 1, 1'b1, 4'h9, 1'b1);
    add(16'h0200, 10, 1'b0, 4'h9, 1'b1);
    add(16'h0000, 2, 1'b0, 4'h9, 1'b1);
    add(16'h0200, 1, 1'b0, 4'h9, 1'b1);
    add(16'h0000, 2, 1'b0, 4'h9, 1'b1);
    add(16'h0000, 1, 1'b0, 4'h9, 1'b0);
    add(16'h0200, 1, 1'b0, 4'h9, 1'b0);
    add(16'h0000, 1, 1'b0, 4'h9, 1'b0);
    add(16'h0200, 1, 1'b0, 4'h9, 1'b0);
    add(16'h0000, 1, 1'b0, 4'h9, 1'b0);
    add(16'h0200, 2, 1'b0, 4'h9, 1'b0);
    add(16'h0200, 1, 1'b1, 4'h9, 1'b1);
    add(16'h0000, 2, 1'b0, 4'h9, 1'b1);
    add(16'h0000, 1, 1'b0, 4'h9, 1'b0);
    add(16'h0042, 5, 1'b0, 4'h9, 1'b0);
    add(16'h8000, 2, 1'b0, 4'h9, 1'b0);
    add(16'h8000, 1, 1'b1, 4'hF, 1'b1);
    add(16'h8008, 2, 1'b0, 4'hF, 1'b1);
    add(16'h0008, 2, 1'b0, 4'hF, 1'b1);
    add(16'h0008, 1, 1'b0, 4'hF, 1'b0);
    add(16'h0008, 2, 1'b0, 4'hF, 1'b0);
    add(16'h0008, 1, 1'b1, 4'h3, 1'b1);
    add(16'h0000, 2, 1'b0, 4'h3, 1'b1);
    add(16'h0000, 1, 1'b0, 4'h3, 1'b0);
    add(16'h0200, 2, 1'b0, 4'h3, 1'b0);
    add(16'h0200, 1, 1'b1, 4'h9, 1'b1);

    foreach (vecs[v]) begin
      for (int r = 0; r < vecs[v].reps; r++) begin
        model_step(vecs[v].mask);
        run_frame(vecs[v].mask, int'(vecs[v].pulse), int'(vecs[v].key),
                  int'(vecs[v].down), $sformatf("vec%0d_%0d", v, r));
      end
    end

    // Disable mid-frame while 9 is held.
    pressed = 16'h0200;
    repeat (5) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    model_disable();
    chk("dis_row", int'(row), 4'hF);
    chk("dis_key_down", int'(key_down), 0);
    chk("dis_key", int'(key), 9);
    chk("dis_key_valid", int'(key_valid), 0);
    repeat (3) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    chk("reen_row", int'(row), 4'b1110);
    for (int f = 0; f < 4; f++) model_frame(16'h0200, $sformatf("reen%0d", f));

    // Reset pulse mid-frame while held: key returns to 0, scan restarts cleanly.
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_row", int'(row), 4'hF);
    chk("midrst_key_down", int'(key_down), 0);
    chk("midrst_key", int'(key), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("postrst_row", int'(row), 4'b1110);
    for (int f = 0; f < 3; f++) model_frame(16'h0200, $sformatf("postrst%0d", f));

    // Random key patterns held for random runs, checked frame by frame against the model.
    rmask = 16'h0000;
    for (int f = 0; f < 48; f++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 5) rmask = rmask;
      else if (sel < 7) rmask = 16'h0000;
      else if (sel < 9) rmask = 16'h0001 << $urandom_range(0, 15);
      else rmask = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      model_frame(rmask, $sformatf("rnd%0d", f));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
